matrix_operand_loader: RTL and testbench
========================================

# matrix_operand_loader

Upstream feeder for the 3x3 matrix multiplier. It accepts 18 operand bytes serially over a valid/ready stream: A row-major, then B row-major. It registers them into two flat operand buses that drive the multiplier's a00..a22 / b00..b22 inputs, then pulses `start`. It holds the operands stable and refuses new input until the multiplier reports `done`.

## Interface
- DATA_W, 8, element width; matches multiplier operand width.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  upstream has an element on `in_data`.
- in_data  input  DATA_W  operand element.
- in_ready  output  1  loader accepts an element this cycle.
- flush  input  1  synchronous; discards a partially loaded set, LOAD state only.
- mul_done  input  1  multiplier completion flag; level or pulse.
- a_flat  output  9*DATA_W  A operands; element a_rc at bits [DATA_W*(3r+c) +: DATA_W].
- b_flat  output  9*DATA_W  B operands; same packing as `a_flat`.
- start  output  1  one-cycle pulse: operands valid, begin multiply.
- busy  output  1  high in START and WAIT states.
- load_count  output  5  elements accepted in the current set, 0..17.

## Operation
- Reset values:
  - state = LOAD, load_count = 0, a_flat = 0, b_flat = 0, start = 0, busy = 0.
  - in_ready = 1, because it is a pure decode of state == LOAD.
- The handshake occurs on a rising edge where in_valid && in_ready.
  - Element index k = load_count.
  - k 0..8 writes A element (r = k/3, c = k%3).
  - k 9..17 writes B element (k-9).
  - Other operand bytes are untouched.
- States:
  - LOAD: in_ready = 1.
    - Each handshake increments load_count.
    - A handshake with k = 17 writes b22, clears load_count to 0, and moves to START.
  - START: start = 1, in_ready = 0, then unconditionally moves to WAIT.
  - WAIT: in_ready = 0. mul_done is sampled each edge. When it is 1, the block moves to LOAD.
- mul_done is ignored in LOAD and START, so a stale `done` from the previous set cannot release WAIT early.
- flush in LOAD sets load_count = 0 and leaves a_flat/b_flat contents as-is (they are overwritten on reload).
  - flush together with a handshake in the same cycle: flush wins and the element is dropped.
  - flush in START/WAIT is ignored.
- a_flat/b_flat are written only on LOAD handshakes, so they are constant from the start pulse until the next set's first handshake.
- No arithmetic beyond load_count increment. load_count never exceeds 17 and never wraps past 17.

## Timing
- The 18th handshake at edge N puts start high for exactly the cycle after N, with all 18 operands already visible.
- WAIT is entered at edge N+1.
- The minimum return to LOAD is when mul_done is high at edge N+2. in_ready is then 1 in the following cycle.
- Set-to-set throughput is 18 + 2 + multiplier latency cycles minimum.
- in_valid may be held high continuously. Back-pressure is via in_ready only; in_data is sampled only on handshake.
- Reset asserted mid-load or mid-WAIT:
  - All outputs go to reset values immediately, without waiting for a clock.
  - A start pulse in flight is cut.
  - Loading restarts at k = 0 after deassertion.

## Test plan
- **Reset:** assert reset mid-cycle -> a_flat = b_flat = 0, start = 0, busy = 0, load_count = 0, in_ready = 1 with no clock edge.
- **Full load:** stream 1..9 then 10..18 with in_valid held high -> a_flat packs a00 = 1 .. a22 = 9, b00 = 10 .. b22 = 18. start is high exactly one cycle after the 18th handshake. in_ready = 0 until mul_done.
- **Gapped valid with stale done:** toggle in_valid every other cycle, holding mul_done = 1 throughout LOAD -> load_count steps only on handshakes, and the block returns to LOAD one edge after entering WAIT. Separately, keep mul_done = 0 for 20 cycles in WAIT -> busy stays 1, operands stay unchanged, no second start.
- **Flush:** load 5 elements, flush (with in_valid = 1) -> load_count = 0 and no element accepted that cycle. The next 18 elements form a correct set.
- **Reset mid-operation:** reset at load_count = 12, and again in WAIT -> immediate reset values. A subsequent full load of values 0xFF yields all-0xFF buses and one start pulse.
- **Back-to-back sets:** two sets with a mul_done pulse between them -> the second set's operands appear and exactly two start pulses are observed.

Source files
------------

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader: gathers 18 operand bytes (A then B, row-major) into flat buses for the 3x3 multiplier.
// Latency: start pulses in the cycle after the 18th handshake, with every operand already visible on a_flat/b_flat.
// Backpressure: in_ready is low from the start pulse until mul_done is seen in WAIT; in_data is sampled only on handshake.
module matrix_operand_loader #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  input  logic                flush,
  input  logic                mul_done,
  output logic [9*DATA_W-1:0] a_flat,
  output logic [9*DATA_W-1:0] b_flat,
  output logic                start,
  output logic                busy,
  output logic [4:0]          load_count
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT
  } state_t;

  // Index of the final operand (b22); its handshake closes the set.
  localparam logic [4:0] LAST_IDX = 5'd17;

  state_t               state;
  state_t               state_nxt;
  logic [4:0]           count_nxt;
  logic                 take;

  // All 18 operands in load order: element k lives at bits [DATA_W*k +: DATA_W].
  // A occupies k = 0..8 and B k = 9..17, so the halves map straight onto the
  // a_rc / b_rc packing (index 3r+c) without any reshuffling.
  logic [18*DATA_W-1:0] ops;

  // A flushed element is dropped, so flush suppresses the write as well.
  assign take = in_valid && (state == ST_LOAD) && !flush;

  assign a_flat = ops[9*DATA_W-1:0];
  assign b_flat = ops[18*DATA_W-1:9*DATA_W];

  // State and element counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      load_count <= 5'd0;
    end else begin
      state      <= state_nxt;
      load_count <= count_nxt;
    end
  end

  // Operand store: written only on LOAD handshakes, so it holds steady through START/WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops <= '0;
    end else if (take) begin
      ops[int'(load_count)*DATA_W +: DATA_W] <= in_data;
    end
  end

  // Next-state, counter update and output decode.
  always_comb begin
    state_nxt = state;
    count_nxt = load_count;
    in_ready  = 1'b0;
    start     = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_LOAD: begin
        // mul_done is deliberately ignored here: a stale done from the
        // previous set must not affect loading.
        in_ready = 1'b1;
        if (flush) begin
          count_nxt = 5'd0;
        end else if (in_valid) begin
          if (load_count == LAST_IDX) begin
            count_nxt = 5'd0;
            state_nxt = ST_START;
          end else begin
            count_nxt = load_count + 5'd1;
          end
        end
      end
      ST_START: begin
        start     = 1'b1;
        busy      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (mul_done) begin
          state_nxt = ST_LOAD;
        end
      end
      default: begin
        state_nxt = ST_LOAD;
        count_nxt = 5'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed testbench for matrix_operand_loader: reset, full load, gapped valid, flush,
// mid-operation reset and back-to-back sets, each checked against hand-computed values.
module tb_matrix_operand_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        mul_done;
  logic [71:0] a_flat;
  logic [71:0] b_flat;
  logic        start;
  logic        busy;
  logic [4:0]  load_count;

  int n_chk;
  int n_pass;
  int start_cnt;

  matrix_operand_loader #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .mul_done   (mul_done),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .start      (start),
    .busy       (busy),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count start pulses away from the active edge; each pulse spans one negedge.
  always @(negedge clk) if (start) start_cnt++;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream 18 elements base, base+inc, ... with in_valid held high; returns in START.
  task automatic load_set(input logic [7:0] base, input logic [7:0] inc);
    for (int k = 0; k < 18; k++) begin
      in_valid = 1'b1;
      in_data  = base + inc * 8'(k);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0) $display("FAIL por_ctrl got rdy=%b busy=%b start=%b exp 1/0/0", in_ready, busy, start); else n_pass++;
    n_chk++; if (a_flat !== 72'h0 || b_flat !== 72'h0 || load_count !== 5'd0) $display("FAIL por_data got a=%h b=%h cnt=%0d exp 0", a_flat, b_flat, load_count); else n_pass++;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h33;
      step();
    end
    in_valid = 1'b0;
    n_chk++; if (load_count !== 5'd3 || a_flat !== 72'h333333) $display("FAIL pre_reset_load got cnt=%0d a=%h exp 3/333333", load_count, a_flat); else n_pass++;
    // Mid-cycle assertion, checked before any further clock edge.
    #2 reset = 1'b1;
    #1;
    n_chk++; if (a_flat !== 72'h0 || b_flat !== 72'h0 || load_count !== 5'd0) $display("FAIL async_reset_data got a=%h b=%h cnt=%0d exp 0", a_flat, b_flat, load_count); else n_pass++;
    n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0 || start !== 1'b0) $display("FAIL async_reset_ctrl got rdy=%b busy=%b start=%b exp 1/0/0", in_ready, busy, start); else n_pass++;
    #1 reset = 1'b0;
    step();
  endtask

  task automatic test_full_load();
    int s0;
    s0 = start_cnt;
    for (int k = 0; k < 18; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(k + 1);
      step();
      if (k == 8) begin
        n_chk++; if (a_flat !== 72'h09_08_07_06_05_04_03_02_01 || b_flat !== 72'h0 || load_count !== 5'd9) $display("FAIL full_a_half got a=%h b=%h cnt=%0d exp 090807060504030201/0/9", a_flat, b_flat, load_count); else n_pass++;
      end
    end
    // in_valid stays high with junk data; it must not be accepted.
    in_data = 8'hEE;
    n_chk++; if (start !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || load_count !== 5'd0) $display("FAIL full_start got start=%b rdy=%b busy=%b cnt=%0d exp 1/0/1/0", start, in_ready, busy, load_count); else n_pass++;
    n_chk++; if (a_flat !== 72'h09_08_07_06_05_04_03_02_01) $display("FAIL full_a got %h exp 090807060504030201", a_flat); else n_pass++;
    n_chk++; if (b_flat !== 72'h12_11_10_0F_0E_0D_0C_0B_0A) $display("FAIL full_b got %h exp 1211100f0e0d0c0b0a", b_flat); else n_pass++;
    step();
    n_chk++; if (start !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL full_wait got start=%b rdy=%b busy=%b exp 0/0/1", start, in_ready, busy); else n_pass++;
    step();
    n_chk++; if (in_ready !== 1'b0 || a_flat !== 72'h09_08_07_06_05_04_03_02_01 || b_flat !== 72'h12_11_10_0F_0E_0D_0C_0B_0A) $display("FAIL full_hold got rdy=%b a=%h b=%h", in_ready, a_flat, b_flat); else n_pass++;
    mul_done = 1'b1;
    step();
    n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0 || load_count !== 5'd0) $display("FAIL full_release got rdy=%b busy=%b cnt=%0d exp 1/0/0", in_ready, busy, load_count); else n_pass++;
    in_valid = 1'b0;
    mul_done = 1'b0;
    n_chk++; if (start_cnt - s0 !== 1) $display("FAIL full_start_count got %0d exp 1", start_cnt - s0); else n_pass++;
  endtask

  task automatic test_gapped_stale_done();
    int s0;
    mul_done = 1'b1;
    for (int k = 0; k < 18; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h20 + 8'(k);
      step();
      n_chk++; if (load_count !== 5'((k + 1) % 18)) $display("FAIL gap_count_hs k=%0d got %0d exp %0d", k, load_count, (k + 1) % 18); else n_pass++;
      in_valid = 1'b0;
      in_data  = 8'hCC;
      if (k < 17) begin
        step();
        n_chk++; if (load_count !== 5'(k + 1)) $display("FAIL gap_count_idle k=%0d got %0d exp %0d", k, load_count, k + 1); else n_pass++;
      end
    end
    n_chk++; if (start !== 1'b1) $display("FAIL gap_start got %b exp 1", start); else n_pass++;
    n_chk++; if (a_flat !== 72'h28_27_26_25_24_23_22_21_20 || b_flat !== 72'h31_30_2F_2E_2D_2C_2B_2A_29) $display("FAIL gap_ops got a=%h b=%h", a_flat, b_flat); else n_pass++;
    step();
    n_chk++; if (busy !== 1'b1 || start !== 1'b0 || in_ready !== 1'b0) $display("FAIL gap_wait got busy=%b start=%b rdy=%b exp 1/0/0", busy, start, in_ready); else n_pass++;
    step();
    n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL gap_release got rdy=%b busy=%b exp 1/0", in_ready, busy); else n_pass++;
    mul_done = 1'b0;

    // Long WAIT with mul_done low: nothing may move.
    s0 = start_cnt;
    load_set(8'h40, 8'd1);
    step();
    for (int i = 0; i < 20; i++) begin
      step();
      n_chk++; if (busy !== 1'b1 || start !== 1'b0 || in_ready !== 1'b0 || a_flat !== 72'h48_47_46_45_44_43_42_41_40 || b_flat !== 72'h51_50_4F_4E_4D_4C_4B_4A_49)
        $display("FAIL wait_hold cyc=%0d got busy=%b start=%b rdy=%b a=%h b=%h", i, busy, start, in_ready, a_flat, b_flat); else n_pass++;
    end
    n_chk++; if (start_cnt - s0 !== 1) $display("FAIL wait_start_count got %0d exp 1", start_cnt - s0); else n_pass++;
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL wait_release got rdy=%b exp 1", in_ready); else n_pass++;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(k);
      step();
    end
    n_chk++; if (load_count !== 5'd5) $display("FAIL flush_pre got %0d exp 5", load_count); else n_pass++;
    in_valid = 1'b1;
    in_data  = 8'h77;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_chk++; if (load_count !== 5'd0 || in_ready !== 1'b1) $display("FAIL flush_count got cnt=%0d rdy=%b exp 0/1", load_count, in_ready); else n_pass++;
    // Old set's upper A bytes remain; the dropped 0x77 must not have landed anywhere.
    n_chk++; if (a_flat !== 72'h48_47_46_45_A4_A3_A2_A1_A0) $display("FAIL flush_keep got %h exp 4847464 5a4a3a2a1a0", a_flat); else n_pass++;
    load_set(8'h50, 8'd1);
    n_chk++; if (start !== 1'b1 || a_flat !== 72'h58_57_56_55_54_53_52_51_50 || b_flat !== 72'h61_60_5F_5E_5D_5C_5B_5A_59) $display("FAIL flush_reload got start=%b a=%h b=%h", start, a_flat, b_flat); else n_pass++;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_chk++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL flush_in_wait got busy=%b rdy=%b exp 1/0", busy, in_ready); else n_pass++;
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s0;
    for (int k = 0; k < 12; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h11;
      step();
    end
    in_valid = 1'b0;
    n_chk++; if (load_count !== 5'd12) $display("FAIL rst_pre got %0d exp 12", load_count); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if (load_count !== 5'd0 || a_flat !== 72'h0 || b_flat !== 72'h0 || in_ready !== 1'b1) $display("FAIL rst_load got cnt=%0d a=%h b=%h rdy=%b", load_count, a_flat, b_flat, in_ready); else n_pass++;
    #1 reset = 1'b0;
    // Reset while the start pulse is up: it must drop at once.
    load_set(8'h11, 8'd0);
    n_chk++; if (start !== 1'b1) $display("FAIL rst_pre_start got %b exp 1", start); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if (start !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || a_flat !== 72'h0) $display("FAIL rst_start_cut got start=%b busy=%b rdy=%b a=%h", start, busy, in_ready, a_flat); else n_pass++;
    #1 reset = 1'b0;
    load_set(8'h22, 8'd0);
    step();
    n_chk++; if (busy !== 1'b1 || start !== 1'b0) $display("FAIL rst_pre_wait got busy=%b start=%b exp 1/0", busy, start); else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1 || a_flat !== 72'h0 || b_flat !== 72'h0 || load_count !== 5'd0) $display("FAIL rst_wait got busy=%b rdy=%b a=%h b=%h cnt=%0d", busy, in_ready, a_flat, b_flat, load_count); else n_pass++;
    #1 reset = 1'b0;
    s0 = start_cnt;
    load_set(8'hFF, 8'd0);
    step();
    step();
    n_chk++; if (a_flat !== {9{8'hFF}} || b_flat !== {9{8'hFF}}) $display("FAIL rst_ff_ops got a=%h b=%h exp all ff", a_flat, b_flat); else n_pass++;
    n_chk++; if (start_cnt - s0 !== 1) $display("FAIL rst_ff_starts got %0d exp 1", start_cnt - s0); else n_pass++;
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = start_cnt;
    load_set(8'h60, 8'd1);
    n_chk++; if (a_flat !== 72'h68_67_66_65_64_63_62_61_60 || b_flat !== 72'h71_70_6F_6E_6D_6C_6B_6A_69) $display("FAIL b2b_first got a=%h b=%h", a_flat, b_flat); else n_pass++;
    step();
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL b2b_release got %b exp 1", in_ready); else n_pass++;
    load_set(8'h80, 8'd1);
    n_chk++; if (start !== 1'b1 || a_flat !== 72'h88_87_86_85_84_83_82_81_80 || b_flat !== 72'h91_90_8F_8E_8D_8C_8B_8A_89) $display("FAIL b2b_second got start=%b a=%h b=%h", start, a_flat, b_flat); else n_pass++;
    step();
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    step();
    step();
    n_chk++; if (start_cnt - s0 !== 2) $display("FAIL b2b_starts got %0d exp 2", start_cnt - s0); else n_pass++;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    start_cnt = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    flush     = 1'b0;
    mul_done  = 1'b0;
    #1;
    test_reset();
    test_full_load();
    test_gapped_stale_done();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
